alu_result_stage: RTL
=====================

Name: alu_result_stage

Overview:
- Registered stage directly downstream of the 32-bit ALU. Captures the ALU's {y_hi, y_lo}, status flags and write-back tag into a small in-order FIFO, and presents one result per handshake to write-back.
- Owns the architected HI/LO registers, which are written when a MUL or DIV entry retires, and the architected C/V/N/Z flag register.
- Flags ADD/SUB signed overflow as a one-cycle trap pulse.

Parameters:
- DEPTH, 2, FIFO entries; power of two, minimum 2.
- PTR_W, 1, pointer width; equals log2(DEPTH).

Ports:
- clk  in  1  Stage clock; all state updates on the rising edge.
- reset  in  1  Asynchronous, active-low reset. Asserting it (0) clears all state immediately; release is synchronous to clk.
- in_valid  in  1  ALU result valid.
- in_ready  out  1  Stage can accept an entry.
- fs  in  5  ALU function select accompanying the result.
- sel  in  2  Result source: 00 = ALU y_lo, 01 = MFHI, 10 = MFLO, 11 = reserved (treated as 00).
- y_hi  in  32  ALU upper result.
- y_lo  in  32  ALU lower result.
- c, v, n, z  in  1 each  ALU status flags.
- wr_en  in  1  Entry writes a GPR.
- wr_addr  in  5  Destination GPR.
- out_valid  out  1  Head entry valid.
- out_ready  in  1  Write-back accepts the head entry.
- out_y  out  32  Head result.
- out_wr_en  out  1  Head GPR write enable; already masked by the trap.
- out_wr_addr  out  5  Head destination.
- hi  out  32  Architected HI register.
- lo  out  32  Architected LO register.
- flags  out  4  Architected {C,V,N,Z}.
- ovf_trap  out  1  One-cycle pulse when a trapping entry retires.

Behaviour:
- Reset (reset = 0, asynchronous): write pointer, read pointer and count = 0; hi = lo = 0; flags = 4'h0; ovf_trap = 0; out_valid = 0; in_ready = 1. FIFO payload contents are don't-care.
- Reset asserted mid-operation: all queued entries are discarded. No retirement side effects occur on that edge.
- Push condition: in_valid && in_ready. in_ready = (count != DEPTH), driven from registered count; no combinational path from out_ready.
- Captured entry fields: {fs, sel, y_hi, y_lo, c, v, n, z, wr_en, wr_addr, trap}.
- trap = (fs == 5'h02 || fs == 5'h04) && v.
- For fs == 1E or 1F, c and v are stored as 0. The ALU drives X on these flags for those codes.
- Pop condition: out_valid && out_ready. out_valid = (count != 0).
- Latency: an entry pushed at edge k is visible on out_* after edge k, i.e. in cycle k+1. There is no same-cycle bypass from in_* to out_*.
- Simultaneous push and pop: count unchanged. When full, in_ready = 0, so no push can happen even if a pop occurs that cycle.
- Pointers wrap modulo DEPTH.
- out_y is combinational from the head entry and the current architected registers:
  - sel 01: out_y = hi.
  - sel 10: out_y = lo.
  - otherwise: out_y = head y_lo.
- Because HI/LO update at retirement and the FIFO is in order, an MFHI/MFLO entry always sees HI/LO written by every older MUL/DIV.
- out_wr_en = head wr_en && !head trap.
- out_wr_addr = head wr_addr.
- Retirement side effects, applied on the pop edge:
  - fs 1E or 1F: hi <= head y_hi, lo <= head y_lo.
  - sel 01/10 (MFHI/MFLO): flags unchanged.
  - all other entries: flags <= {c, v, n, z} of the head entry.
  - ovf_trap is 1 for exactly the cycle after a pop of a trap entry, else 0.
- HI/LO are never written by non-MUL/DIV entries, including trapping ones.
- out_* values are don't-care while out_valid = 0. hi, lo and flags are always valid.

Test Plan:
- Reset then idle: hi = lo = 0, flags = 0, out_valid = 0, in_ready = 1. Assert reset low mid-stream with 2 entries queued: all outputs return to their reset values on the same cycle, without waiting for clk.
- Push fs = 1E, y_hi = 32'h0000_0001, y_lo = 32'h8000_0000, out_ready = 1: out_valid rises the next cycle. After the pop, hi = 1, lo = 32'h8000_0000, flags = {0, 0, n, z} as supplied.
- Back-to-back push of MUL (y_hi = 32'hDEAD_BEEF) then sel = 01 while out_ready = 0: FIFO full and in_ready = 0. Release out_ready: first pop updates hi; second pop shows out_y = 32'hDEAD_BEEF and flags unchanged.
- Push fs = 02, v = 1, wr_en = 1, wr_addr = 5'd9: at pop, out_wr_en = 0, ovf_trap pulses 1 for one cycle, flags V = 1, hi/lo unchanged.
- Steady stream of 20 entries with in_valid = 1 and random out_ready: order preserved, none lost or duplicated, count never exceeds DEPTH, push+pop when count = 1 keeps count at 1.
- fs = 1F with c = v = X input: stored and retired flags have C = V = 0, with no X propagation onto flags.

Source files
------------

// File: rtl/alu_result_stage.sv
// Result stage behind the 32-bit ALU: in-order result FIFO feeding write-back,
// plus the architected HI/LO and C/V/N/Z registers, which update when an entry retires.
module alu_result_stage #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned PTR_W = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  fs,
  input  logic [1:0]  sel,
  input  logic [31:0] y_hi,
  input  logic [31:0] y_lo,
  input  logic        c,
  input  logic        v,
  input  logic        n,
  input  logic        z,
  input  logic        wr_en,
  input  logic [4:0]  wr_addr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_y,
  output logic        out_wr_en,
  output logic [4:0]  out_wr_addr,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [3:0]  flags,
  output logic        ovf_trap
);

  localparam int unsigned CNT_W    = PTR_W + 1;
  localparam logic [4:0]  FS_ADD   = 5'h02;
  localparam logic [4:0]  FS_SUB   = 5'h04;
  localparam logic [4:0]  FS_MUL   = 5'h1E;
  localparam logic [4:0]  FS_DIV   = 5'h1F;
  localparam logic [1:0]  SEL_MFHI = 2'b01;
  localparam logic [1:0]  SEL_MFLO = 2'b10;

  typedef struct packed {
    logic [4:0]  fs;
    logic [1:0]  sel;
    logic [31:0] y_hi;
    logic [31:0] y_lo;
    logic        c;
    logic        v;
    logic        n;
    logic        z;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic        trap;
  } entry_t;

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;

  entry_t             in_entry_c;
  entry_t             head_c;
  logic               push_c;
  logic               pop_c;
  logic               in_muldiv_c;
  logic               head_muldiv_c;
  logic               head_mf_c;

  assign in_ready  = (count != CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign push_c    = in_valid && in_ready;
  assign pop_c     = out_valid && out_ready;
  assign head_c    = mem[rd_ptr];

  // MUL/DIV leave C/V undefined on the ALU side, so they are forced to 0 on capture.
  always_comb begin
    in_muldiv_c        = (fs == FS_MUL) || (fs == FS_DIV);
    in_entry_c         = '0;
    in_entry_c.fs      = fs;
    in_entry_c.sel     = sel;
    in_entry_c.y_hi    = y_hi;
    in_entry_c.y_lo    = y_lo;
    in_entry_c.c       = in_muldiv_c ? 1'b0 : c;
    in_entry_c.v       = in_muldiv_c ? 1'b0 : v;
    in_entry_c.n       = n;
    in_entry_c.z       = z;
    in_entry_c.wr_en   = wr_en;
    in_entry_c.wr_addr = wr_addr;
    in_entry_c.trap    = ((fs == FS_ADD) || (fs == FS_SUB)) && v;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_c, pop_c})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr] <= in_entry_c;
  end

  always_comb begin
    head_muldiv_c = (head_c.fs == FS_MUL) || (head_c.fs == FS_DIV);
    head_mf_c     = (head_c.sel == SEL_MFHI) || (head_c.sel == SEL_MFLO);
  end

  // Architected state changes only when the head retires.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi       <= '0;
      lo       <= '0;
      flags    <= '0;
      ovf_trap <= 1'b0;
    end else begin
      ovf_trap <= pop_c && head_c.trap;
      if (pop_c) begin
        if (head_muldiv_c) begin
          hi <= head_c.y_hi;
          lo <= head_c.y_lo;
        end
        if (!head_mf_c) flags <= {head_c.c, head_c.v, head_c.n, head_c.z};
      end
    end
  end

  // MFHI/MFLO read the architected registers, which already hold every older MUL/DIV.
  always_comb begin
    out_y       = head_c.y_lo;
    out_wr_en   = head_c.wr_en && !head_c.trap;
    out_wr_addr = head_c.wr_addr;
    case (head_c.sel)
      SEL_MFHI: out_y = hi;
      SEL_MFLO: out_y = lo;
      default:  out_y = head_c.y_lo;
    endcase
  end

endmodule
